tetris_frame_timer_master: RTL and testbench



---
 rtl/tetris_frame_timer_master.sv | 226 ++++++++++++++++++++++
 tb/tb_tetris_frame_timer_master.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_frame_timer_master.sv
// Avalon-MM master that programs the frame interval timer and turns each acknowledged IRQ into a frame tick.
// Optional start readback check (RUN bit of status) is enabled by defining FRAME_MASTER_READBACK_EN.
module tetris_frame_timer_master #(
  parameter logic [31:0] DEFAULT_PERIOD = 32'h000CBDB7,
  parameter int unsigned FRAME_CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cfg_start,
  input  logic                   cfg_stop,
  input  logic [31:0]            cfg_period,
  output logic [2:0]             av_address,
  output logic                   av_chipselect,
  output logic                   av_write_n,
  output logic [15:0]            av_writedata,
  input  logic [15:0]            av_readdata,
  input  logic                   timer_irq,
  output logic                   frame_tick,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   busy,
  output logic                   running,
  output logic                   err_flag
);

  // state  | meaning
  // IDLE   | timer not serviced, bus idle
  // S_STOP | write control = stop, irq disabled
  // S_PERL | write period low half
  // S_PERH | write period high half
  // S_CLR  | clear stale timeout in status
  // S_CTRL | write control = START|CONT|ITO
  // S_RD   | read status twice, check RUN bit (readback build only)
  // RUN    | waiting for timer irq
  // ACK    | clear status, emit frame tick
  // P_STOP | write control = stop
  // P_CLR  | clear status, then IDLE
  typedef enum logic [3:0] {
    IDLE, S_STOP, S_PERL, S_PERH, S_CLR, S_CTRL, S_RD, RUN, ACK, P_STOP, P_CLR
  } state_t;

  localparam logic [2:0]  A_STATUS  = 3'd0;
  localparam logic [2:0]  A_CONTROL = 3'd1;
  localparam logic [2:0]  A_PERL    = 3'd2;
  localparam logic [2:0]  A_PERH    = 3'd3;
  localparam logic [15:0] CTRL_STOP = 16'h0008;
  localparam logic [15:0] CTRL_GO   = 16'h0007;
  localparam logic [FRAME_CNT_W-1:0] CNT_ONE = {{(FRAME_CNT_W-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [31:0]            period_q, period_d;
  logic [FRAME_CNT_W-1:0] count_q, count_d;
  logic [2:0]             addr_q, addr_d;
  logic                   cs_q, cs_d;
  logic                   wn_q, wn_d;
  logic [15:0]            wd_q, wd_d;
  logic                   tick_q, tick_d;
  logic                   busy_q, busy_d;
  logic                   run_q, run_d;
  logic                   start_ok;

`ifdef FRAME_MASTER_READBACK_EN
  logic err_q, err_d;
  logic rd_cnt_q, rd_cnt_d;
`endif

  // Stop outranks start; start is only honoured when idle or running.
  assign start_ok = cfg_start && !cfg_stop && (state_q == IDLE || state_q == RUN);

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    count_d  = count_q;
`ifdef FRAME_MASTER_READBACK_EN
    err_d    = err_q;
    rd_cnt_d = rd_cnt_q;
`endif
    case (state_q)
      IDLE:   if (start_ok) state_d = S_STOP;
      S_STOP: state_d = S_PERL;
      S_PERL: state_d = S_PERH;
      S_PERH: state_d = S_CLR;
      S_CLR:  state_d = S_CTRL;
      S_CTRL: begin
`ifdef FRAME_MASTER_READBACK_EN
        state_d  = S_RD;
        rd_cnt_d = 1'b1;
`else
        state_d  = RUN;
`endif
      end
`ifdef FRAME_MASTER_READBACK_EN
      S_RD: begin
        if (rd_cnt_q) begin
          rd_cnt_d = 1'b0;
        end else if (av_readdata[1]) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
`endif
      RUN: begin
        if (cfg_stop) begin
          state_d = P_STOP;
        end else if (start_ok) begin
          state_d = S_STOP;
        end else if (timer_irq) begin
          state_d = ACK;
          count_d = count_q + CNT_ONE;
        end
      end
      ACK:    state_d = cfg_stop ? P_STOP : RUN;
      P_STOP: state_d = P_CLR;
      P_CLR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (start_ok) begin
      period_d = (cfg_period == 32'd0) ? DEFAULT_PERIOD : cfg_period;
      count_d  = '0;
`ifdef FRAME_MASTER_READBACK_EN
      err_d    = 1'b0;
`endif
    end
  end

  // Bus and flag outputs are decoded from the next state so they register alongside it.
  always_comb begin
    cs_d   = 1'b0;
    wn_d   = 1'b1;
    addr_d = A_STATUS;
    wd_d   = '0;
    case (state_d)
      S_STOP, P_STOP: begin
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        addr_d = A_CONTROL;
        wd_d   = CTRL_STOP;
      end
      S_PERL: begin
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        addr_d = A_PERL;
        wd_d   = period_d[15:0];
      end
      S_PERH: begin
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        addr_d = A_PERH;
        wd_d   = period_d[31:16];
      end
      S_CLR, ACK, P_CLR: begin
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        addr_d = A_STATUS;
      end
      S_CTRL: begin
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        addr_d = A_CONTROL;
        wd_d   = CTRL_GO;
      end
      S_RD: cs_d = 1'b1;
      default: ;
    endcase
  end

  assign busy_d = state_d inside {S_STOP, S_PERL, S_PERH, S_CLR, S_CTRL, S_RD, P_STOP, P_CLR};
  assign run_d  = (state_d == RUN) || (state_d == ACK);
  assign tick_d = (state_d == ACK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      period_q <= DEFAULT_PERIOD;
      count_q  <= '0;
      addr_q   <= A_STATUS;
      cs_q     <= 1'b0;
      wn_q     <= 1'b1;
      wd_q     <= '0;
      tick_q   <= 1'b0;
      busy_q   <= 1'b0;
      run_q    <= 1'b0;
`ifdef FRAME_MASTER_READBACK_EN
      err_q    <= 1'b0;
      rd_cnt_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      cs_q     <= cs_d;
      wn_q     <= wn_d;
      wd_q     <= wd_d;
      tick_q   <= tick_d;
      busy_q   <= busy_d;
      run_q    <= run_d;
`ifdef FRAME_MASTER_READBACK_EN
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
`endif
    end
  end

  assign av_address    = addr_q;
  assign av_chipselect = cs_q;
  assign av_write_n    = wn_q;
  assign av_writedata  = wd_q;
  assign frame_tick    = tick_q;
  assign frame_count   = count_q;
  assign busy          = busy_q;
  assign running       = run_q;

`ifdef FRAME_MASTER_READBACK_EN
  logic rd_unused;
  assign rd_unused = ^{av_readdata[15:2], av_readdata[0]};
  assign err_flag  = err_q;
`else
  logic rd_unused;
  assign rd_unused = ^av_readdata;
  assign err_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_tetris_frame_timer_master.sv
// Scoreboard bench for tetris_frame_timer_master: a cycle-level behavioural model predicts bus writes and flags.
module tb_tetris_frame_timer_master;

  localparam int          CW      = 8;
  localparam logic [31:0] DEF_PER = 32'h000CBDB7;
  localparam int M_IDLE = 0, M_BUSY = 1, M_RUN = 2, M_ACK = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_stop = 1'b0;
  logic [31:0]   cfg_period = '0;
  logic [2:0]    av_address;
  logic          av_chipselect;
  logic          av_write_n;
  logic [15:0]   av_writedata;
  logic [15:0]   av_readdata = 16'h0002;
  logic          timer_irq = 1'b0;
  logic          frame_tick;
  logic [CW-1:0] frame_count;
  logic          busy;
  logic          running;
  logic          err_flag;

  always #5 clk = ~clk;

  tetris_frame_timer_master #(.DEFAULT_PERIOD(DEF_PER), .FRAME_CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_period(cfg_period), .av_address(av_address), .av_chipselect(av_chipselect),
    .av_write_n(av_write_n), .av_writedata(av_writedata), .av_readdata(av_readdata),
    .timer_irq(timer_irq), .frame_tick(frame_tick), .frame_count(frame_count),
    .busy(busy), .running(running), .err_flag(err_flag)
  );

  typedef struct { logic [2:0] addr; logic [15:0] data; } wr_t;
  typedef struct { bit busy; bit running; bit tick; bit wr; int count; } cyc_t;

  wr_t  wr_q[$];
  cyc_t cyc_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  int   m_mode = M_IDLE, m_left = 0, m_after = M_IDLE, m_count = 0;
  bit   clr_pending = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [2:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic begin_prog(input logic [31:0] per_in);
    logic [31:0] per;
    per = (per_in == 32'd0) ? DEF_PER : per_in;
    push_wr(3'd1, 16'h0008);
    push_wr(3'd2, per[15:0]);
    push_wr(3'd3, per[31:16]);
    push_wr(3'd0, 16'h0000);
    push_wr(3'd1, 16'h0007);
    m_mode  = M_BUSY;
    m_left  = 5;
    m_after = M_RUN;
    m_count = 0;
  endtask

  task automatic begin_stop();
    push_wr(3'd1, 16'h0008);
    push_wr(3'd0, 16'h0000);
    m_mode  = M_BUSY;
    m_left  = 2;
    m_after = M_IDLE;
  endtask

  // Advance the model across the coming clock edge and predict the following cycle.
  task automatic model_step();
    cyc_t c;
    case (m_mode)
      M_IDLE: if (cfg_start && !cfg_stop) begin_prog(cfg_period);
      M_BUSY: begin
        m_left--;
        if (m_left == 0) m_mode = m_after;
      end
      M_RUN: begin
        if (cfg_stop) begin_stop();
        else if (cfg_start) begin_prog(cfg_period);
        else if (timer_irq) begin
          m_count = (m_count + 1) % (1 << CW);
          push_wr(3'd0, 16'h0000);
          m_mode = M_ACK;
        end
      end
      M_ACK: begin
        if (cfg_stop) begin_stop();
        else m_mode = M_RUN;
      end
      default: m_mode = M_IDLE;
    endcase
    c.busy    = (m_mode == M_BUSY);
    c.running = (m_mode == M_RUN) || (m_mode == M_ACK);
    c.tick    = (m_mode == M_ACK);
    c.wr      = (m_mode == M_BUSY) || (m_mode == M_ACK);
    c.count   = m_count;
    cyc_q.push_back(c);
  endtask

  // One stimulus cycle: drive inputs, emulate the slave irq (status write clears it at the next edge).
  task automatic cycle(input bit st, input bit sp, input bit fire, input logic [31:0] per);
    bit clr_now;
    @(negedge clk);
    cfg_start  = st;
    cfg_stop   = sp;
    cfg_period = per;
    clr_now = av_chipselect && !av_write_n && (av_address == 3'd0);
    if (clr_pending) timer_irq = 1'b0;
    if (fire && !clr_now) timer_irq = 1'b1;
    clr_pending = clr_now;
    model_step();
    mon_en = 1'b1;
  endtask

  always begin : monitor
    cyc_t e;
    wr_t  w;
    bit   wr_now;
    @(posedge clk);
    #1;
    if (mon_en && reset_n) begin
      if (cyc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cycle_queue: got empty queue, expected a predicted cycle at %0t", $time);
      end else begin
        e = cyc_q.pop_front();
        wr_now = av_chipselect && !av_write_n;
        chk("busy", busy, e.busy);
        chk("running", running, e.running);
        chk("frame_tick", frame_tick, e.tick);
        chk("frame_count", frame_count, e.count);
        chk("bus_write", wr_now, e.wr);
        chk("err_flag", err_flag, 0);
        if (wr_now) begin
          if (wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL write_queue: got write addr %0h data %0h, expected none", av_address, av_writedata);
          end else begin
            w = wr_q.pop_front();
            chk("wr_addr", av_address, w.addr);
            chk("wr_data", av_writedata, w.data);
          end
        end
      end
    end
  end

  initial begin
    bit st, sp, fi;
    int r;
    logic [31:0] per;

    repeat (3) @(negedge clk);
    chk("rst_address", av_address, 0);
    chk("rst_chipselect", av_chipselect, 0);
    chk("rst_write_n", av_write_n, 1);
    chk("rst_writedata", av_writedata, 0);
    chk("rst_frame_tick", frame_tick, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_running", running, 0);
    chk("rst_err_flag", err_flag, 0);
    reset_n = 1'b1;

    repeat (10) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 32'h0001_0064);
    repeat (8) cycle(0, 0, 0, 0);
    repeat (3) begin
      cycle(0, 0, 1, 0);
      repeat (3) cycle(0, 0, 0, 0);
    end
    cycle(1, 0, 0, 32'hABCD_1234);
    repeat (8) cycle(0, 0, 0, 0);
    cycle(0, 1, 1, 0);
    repeat (4) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 32'h0000_0000);
    repeat (8) cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0);
    repeat (4) cycle(0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 99);
      fi = ($urandom_range(0, 3) == 0);
      st = (r < 3) && (m_mode != M_RUN);
      sp = (r >= 3) && (r < 5);
      per = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      cycle(st, sp, fi, per);
    end

    repeat (10) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    repeat (10) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, $urandom);
    repeat (8) cycle(0, 0, 0, 0);
    repeat (700) cycle(0, 0, 1, 0);
    cycle(0, 1, 1, 0);
    repeat (8) cycle(0, 0, 0, 0);
    chk("writes_drained", wr_q.size(), 0);

    cycle(1, 0, 0, 32'h0000_1234);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    @(negedge clk);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_chipselect", av_chipselect, 0);
    chk("midrst_write_n", av_write_n, 1);
    chk("midrst_busy", busy, 0);
    cyc_q.delete();
    wr_q.delete();
    m_mode = M_IDLE;
    m_count = 0;
    timer_irq = 1'b0;
    clr_pending = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) cycle(0, 0, 0, 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
